// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: PC, IR, field decode and next-PC selection.
// Optional retired-instruction counter enabled by defining IFETCH_COUNT_EN.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_ren,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    input  logic        next_req,
    input  logic [1:0]  pc_src,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [5:0]  func,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [31:0] imm_sext,
    output logic        instr_valid,
    output logic        misaligned,
    output logic [31:0] instr_count
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q;
    logic        misaligned_q;
    logic        ir_load;
    logic        pc_load;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = (LAT_M1 == 4'd0) ? S_VALID : S_WAIT;
            S_WAIT:  if (cnt_q == 4'd1) state_d = S_VALID;
            S_VALID: if (next_req) state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // mem_ren is gated by reset so an in-flight read drops the instant reset asserts.
    always_comb begin
        mem_ren     = 1'b0;
        instr_valid = 1'b0;
        ir_load     = 1'b0;
        pc_load     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_ren = ~reset;
                ir_load = (LAT_M1 == 4'd0);
            end
            S_WAIT: begin
                mem_ren = ~reset;
                ir_load = (cnt_q == 4'd1);
            end
            S_VALID: begin
                instr_valid = 1'b1;
                pc_load     = next_req;
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        case (state_q)
            S_FETCH: cnt_d = LAT_M1;
            S_WAIT:  cnt_d = cnt_q - 4'd1;
            default: ;
        endcase
    end

    always_comb begin
        case (pc_src)
            2'b00:   pc_d = pc_plus4;
            2'b01:   pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
            2'b10:   pc_d = {pc_plus4[31:28], ir_q[25:0], 2'b00};
            default: pc_d = {jr_target[31:2], 2'b00};
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q        <= 4'd0;
            pc_q         <= RESET_PC;
            ir_q         <= 32'h0;
            misaligned_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (ir_load) ir_q <= mem_dout;
            if (pc_load) begin
                pc_q <= pc_d;
                if (pc_src == 2'b11 && jr_target[1:0] != 2'b00) misaligned_q <= 1'b1;
            end
        end
    end

`ifdef IFETCH_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= 32'h0;
        end else if (pc_load) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = 32'h0;
`endif

    assign pc         = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign mem_addr   = {2'b00, pc_q[31:2]};
    assign ir         = ir_q;
    assign misaligned = misaligned_q;
    assign opcode     = ir_q[31:26];
    assign rs         = ir_q[25:21];
    assign rt         = ir_q[20:16];
    assign rd         = ir_q[15:11];
    assign func       = ir_q[5:0];
    assign imm_sext   = {{16{ir_q[15]}}, ir_q[15:0]};

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench: fetch expectations are queued at issue time and checked
// by a monitor whenever instr_valid rises. A second instance covers MEM_LATENCY=1.
module tb_instr_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        next_req = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] jr_target = 32'h0;

    logic        mem_ren, instr_valid, misaligned;
    logic [31:0] mem_addr, mem_dout, pc, pc_plus4, ir, imm_sext, instr_count;
    logic [5:0]  opcode, func;
    logic [4:0]  rs, rt, rd;

    logic        b_mem_ren, b_instr_valid, b_misaligned;
    logic [31:0] b_mem_addr, b_mem_dout, b_pc, b_pc_plus4, b_ir, b_imm_sext, b_instr_count;
    logic [5:0]  b_opcode, b_func;
    logic [4:0]  b_rs, b_rt, b_rd;
    logic        b_next_req = 1'b0;
    logic [1:0]  b_pc_src = 2'b00;
    logic [31:0] b_jr_target = 32'h0;

    int checks = 0;
    int failures = 0;
    int cnt_model = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        mis;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h2008_0005;
            32'h1:   return 32'h0800_0010;
            32'h2:   return 32'h1000_FFFE;
            32'h10:  return 32'h03E0_0008;
            default: return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    assign mem_dout   = mem_word(mem_addr);
    assign b_mem_dout = mem_word(b_mem_addr);

    instr_fetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(3)) u_dut (
        .clock(clock), .reset(reset), .mem_ren(mem_ren), .mem_addr(mem_addr),
        .mem_dout(mem_dout), .next_req(next_req), .pc_src(pc_src), .jr_target(jr_target),
        .pc(pc), .pc_plus4(pc_plus4), .ir(ir), .opcode(opcode), .func(func),
        .rs(rs), .rt(rt), .rd(rd), .imm_sext(imm_sext), .instr_valid(instr_valid),
        .misaligned(misaligned), .instr_count(instr_count)
    );

    instr_fetch_unit #(.RESET_PC(32'h0), .MEM_LATENCY(1)) u_dut_lat1 (
        .clock(clock), .reset(reset), .mem_ren(b_mem_ren), .mem_addr(b_mem_addr),
        .mem_dout(b_mem_dout), .next_req(b_next_req), .pc_src(b_pc_src), .jr_target(b_jr_target),
        .pc(b_pc), .pc_plus4(b_pc_plus4), .ir(b_ir), .opcode(b_opcode), .func(b_func),
        .rs(b_rs), .rt(b_rt), .rd(b_rd), .imm_sext(b_imm_sext), .instr_valid(b_instr_valid),
        .misaligned(b_misaligned), .instr_count(b_instr_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef IFETCH_COUNT_EN
        return 32'(cnt_model);
`else
        return 32'h0;
`endif
    endfunction

    task automatic wait_valid();
        for (int i = 0; i < 100 && !instr_valid; i++) begin
            @(posedge clock);
            #2;
        end
        chk("wait_valid", {31'b0, instr_valid}, 32'h1);
    endtask

    task automatic do_next(input logic [1:0] src, input logic [31:0] jr,
                           input logic [31:0] e_pc, input logic [31:0] e_ir, input logic e_mis);
        exp_t e;
        wait_valid();
        next_req  = 1'b1;
        pc_src    = src;
        jr_target = jr;
        cnt_model++;
        e.pc = e_pc; e.ir = e_ir; e.mis = e_mis; e.cnt = exp_cnt();
        sb_q.push_back(e);
        @(posedge clock);
        #2;
        next_req = 1'b0;
    endtask

    // Monitor for both instances, sampled on the falling edge.
    initial begin
        int   ren_cnt, b_ren_cnt;
        logic prev_v, b_prev_v;
        exp_t e;
        ren_cnt = 0; b_ren_cnt = 0; prev_v = 1'b0; b_prev_v = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                ren_cnt = 0; b_ren_cnt = 0; prev_v = 1'b0; b_prev_v = 1'b0;
            end else begin
                if (mem_ren) ren_cnt++;
                if (instr_valid && !prev_v) begin
                    chk("ren_cycles", 32'(ren_cnt), 32'd3);
                    ren_cnt = 0;
                    if (sb_q.size() == 0) begin
                        chk("sb_nonempty", 32'd0, 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("pc", pc, e.pc);
                        chk("pc_plus4", pc_plus4, e.pc + 32'd4);
                        chk("mem_addr", mem_addr, {2'b00, e.pc[31:2]});
                        chk("ir", ir, e.ir);
                        chk("opcode", {26'b0, opcode}, {26'b0, e.ir[31:26]});
                        chk("rs", {27'b0, rs}, {27'b0, e.ir[25:21]});
                        chk("rt", {27'b0, rt}, {27'b0, e.ir[20:16]});
                        chk("rd", {27'b0, rd}, {27'b0, e.ir[15:11]});
                        chk("func", {26'b0, func}, {26'b0, e.ir[5:0]});
                        chk("imm_sext", imm_sext, {{16{e.ir[15]}}, e.ir[15:0]});
                        chk("misaligned", {31'b0, misaligned}, {31'b0, e.mis});
                        chk("instr_count", instr_count, e.cnt);
                    end
                end
                prev_v = instr_valid;

                if (b_mem_ren) b_ren_cnt++;
                if (b_instr_valid && !b_prev_v) begin
                    chk("lat1_ren_cycles", 32'(b_ren_cnt), 32'd1);
                    chk("lat1_ir", b_ir, 32'h2008_0005);
                    chk("lat1_opcode", {26'b0, b_opcode}, 32'h08);
                    chk("lat1_rt", {27'b0, b_rt}, 32'd8);
                    chk("lat1_imm", b_imm_sext, 32'd5);
                    chk("lat1_pc", b_pc, 32'h0);
                    b_ren_cnt = 0;
                end
                b_prev_v = b_instr_valid;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        #1;
        chk("rst_mem_ren", {31'b0, mem_ren}, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
        chk("rst_count", instr_count, 32'h0);
        @(posedge clock);
        @(posedge clock);
        #2;
        e.pc = 32'h0; e.ir = 32'h2008_0005; e.mis = 1'b0; e.cnt = 32'h0;
        sb_q.push_back(e);
        reset = 1'b0;

        do_next(2'b00, 32'h0,         32'h0000_0004, 32'h0800_0010, 1'b0);
        do_next(2'b00, 32'h0,         32'h0000_0008, 32'h1000_FFFE, 1'b0);
        do_next(2'b01, 32'h0,         32'h0000_0004, 32'h0800_0010, 1'b0);
        do_next(2'b10, 32'h0,         32'h0000_0040, 32'h03E0_0008, 1'b0);
        do_next(2'b11, 32'h0000_0103, 32'h0000_0100, 32'hC0DE_0040, 1'b1);
        do_next(2'b00, 32'h0,         32'h0000_0104, 32'hC0DE_0041, 1'b1);
        do_next(2'b11, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hC0DE_FFFF, 1'b1);
        do_next(2'b00, 32'h0,         32'h0000_0000, 32'h2008_0005, 1'b1);

        // next_req pulsed while the read is in WAIT must not move the PC
        do_next(2'b00, 32'h0,         32'h0000_0004, 32'h0800_0010, 1'b1);
        @(posedge clock);
        #2;
        next_req = 1'b1;
        pc_src   = 2'b01;
        @(posedge clock);
        #2;
        next_req = 1'b0;
        chk("ignore_pc", pc, 32'h0000_0004);
        chk("ignore_ren", {31'b0, mem_ren}, 32'h1);

        // reset asserted mid-WAIT
        do_next(2'b00, 32'h0,         32'h0000_0008, 32'h1000_FFFE, 1'b1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_mem_ren", {31'b0, mem_ren}, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_valid", {31'b0, instr_valid}, 32'h0);
        chk("midrst_misaligned", {31'b0, misaligned}, 32'h0);
        chk("midrst_count", instr_count, 32'h0);
        sb_q.delete();
        cnt_model = 0;
        @(posedge clock);
        #2;
        e.pc = 32'h0; e.ir = 32'h2008_0005; e.mis = 1'b0; e.cnt = 32'h0;
        sb_q.push_back(e);
        reset = 1'b0;

        do_next(2'b00, 32'h0, 32'h0000_0004, 32'h0800_0010, 1'b0);
        do_next(2'b00, 32'h0, 32'h0000_0008, 32'h1000_FFFE, 1'b0);
        do_next(2'b00, 32'h0, 32'h0000_000C, 32'hC0DE_0003, 1'b0);
        do_next(2'b00, 32'h0, 32'h0000_0010, 32'hC0DE_0004, 1'b0);
        do_next(2'b00, 32'h0, 32'h0000_0014, 32'hC0DE_0005, 1'b0);
        wait_valid();
        repeat (2) @(negedge clock);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
`ifdef IFETCH_COUNT_EN
        chk("final_count", instr_count, 32'd5);
`else
        chk("final_count", instr_count, 32'd0);
`endif
        chk("final_misaligned", {31'b0, misaligned}, 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
